// File: rtl/pc_stack_unit.sv
// pc_stack_unit
//   Program-counter sequencer with a hardware call/data stack. On each
//   retire strobe (step) in RUN, one control-flow action is taken. The
//   priority order is CALL > RET > JMP > PUSH > POP > GSA > sequential
//   increment. A stack overflow or underflow parks the block in FAULT
//   until clear_fault is asserted.
//
//   state | meaning
//   RUN   | normal sequencing, step honoured
//   FAULT | stack overflow/underflow seen, step ignored until clear_fault
//
// Ports
//   clk, rst_n                     clock, async active-low reset
//   step                           retire strobe qualifying the flags
//   JMP/CALL/RET/PUSH/POP/GSA_flag control-flow decoder flags
//   Kernel_flag                    JMP also raises kernel_mode
//   Mini_ALU_op/v1/v2              target = v1 +/- v2 (op[0]), value operands
//   clear_fault                    leave FAULT
//   PC_pos                         current program counter
//   wb_valid/wb_reg/wb_data        registered one-cycle write-back
//   stack_empty/stack_full         occupancy flags
//   kernel_mode, fault, fault_code privilege and fault status
module pc_stack_unit #(
  parameter int STACK_DEPTH = 16,
  parameter int PC_WIDTH    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                step,
  input  logic                JMP_flag,
  input  logic                CALL_flag,
  input  logic                RET_flag,
  input  logic                PUSH_flag,
  input  logic                POP_flag,
  input  logic                GSA_flag,
  input  logic                Kernel_flag,
  input  logic [3:0]          Mini_ALU_op,
  input  logic [31:0]         Mini_ALU_v1,
  input  logic [31:0]         Mini_ALU_v2,
  input  logic                clear_fault,
  output logic [PC_WIDTH-1:0] PC_pos,
  output logic                wb_valid,
  output logic [7:0]          wb_reg,
  output logic [31:0]         wb_data,
  output logic                stack_empty,
  output logic                stack_full,
  output logic                kernel_mode,
  output logic                fault,
  output logic [1:0]          fault_code
);

  localparam int IDX_W = $clog2(STACK_DEPTH);
  localparam int SP_W  = IDX_W + 1;
  localparam logic [SP_W-1:0] FULL_CNT = SP_W'(STACK_DEPTH);

  typedef enum logic {RUN, FAULT} state_t;

  state_t              state;
  logic [PC_WIDTH-1:0] pc;
  logic [SP_W-1:0]     sp;
  logic [SP_W-1:0]     sp_m1;
  logic [31:0]         stack_mem [STACK_DEPTH];
  logic [31:0]         alu_res;
  logic [PC_WIDTH-1:0] target;
  logic [PC_WIDTH-1:0] pc_inc;
  logic [31:0]         top_entry;
  logic                is_empty;
  logic                is_full;
  logic                push_en;
  logic [31:0]         push_data;
  logic                unused_ok;

  assign alu_res   = Mini_ALU_op[0] ? (Mini_ALU_v1 - Mini_ALU_v2) : (Mini_ALU_v1 + Mini_ALU_v2);
  assign target    = PC_WIDTH'(alu_res);
  assign pc_inc    = pc + 1'b1;
  assign sp_m1     = sp - 1'b1;
  assign top_entry = stack_mem[sp_m1[IDX_W-1:0]];
  assign is_empty  = (sp == '0);
  assign is_full   = (sp == FULL_CNT);

  // Only op[0] is meaningful; upper ALU bits are dropped when forming target.
  assign unused_ok = ^{Mini_ALU_op[3:1], alu_res};

  assign PC_pos      = pc;
  assign stack_empty = is_empty;
  assign stack_full  = is_full;

  // Stack write port: only CALL and PUSH write, and only when they win
  // arbitration and the stack has room.
  always_comb begin
    push_en   = 1'b0;
    push_data = 32'd0;
    if (state == RUN && step) begin
      if (CALL_flag) begin
        push_en   = !is_full;
        push_data = 32'(pc_inc);
      end else if (!RET_flag && !JMP_flag && PUSH_flag) begin
        push_en   = !is_full;
        push_data = Mini_ALU_v1;
      end
    end
  end

  // Contents are don't-care after reset, so the array carries no reset.
  always_ff @(posedge clk) begin
    if (push_en) stack_mem[sp[IDX_W-1:0]] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      pc          <= '0;
      sp          <= '0;
      kernel_mode <= 1'b0;
      fault       <= 1'b0;
      fault_code  <= 2'b00;
      wb_valid    <= 1'b0;
      wb_reg      <= 8'd0;
      wb_data     <= 32'd0;
    end else begin
      wb_valid <= 1'b0;
      if (state == RUN) begin
        if (step) begin
          if (CALL_flag) begin
            if (is_full) begin
              state      <= FAULT;
              fault      <= 1'b1;
              fault_code <= 2'b01;
            end else begin
              sp <= sp + 1'b1;
              pc <= target;
            end
          end else if (RET_flag) begin
            if (is_empty) begin
              state      <= FAULT;
              fault      <= 1'b1;
              fault_code <= 2'b10;
            end else begin
              sp          <= sp_m1;
              pc          <= top_entry[PC_WIDTH-1:0];
              kernel_mode <= 1'b0;
            end
          end else if (JMP_flag) begin
            // A self-target (HALT) naturally holds PC here.
            pc <= target;
            if (Kernel_flag) kernel_mode <= 1'b1;
          end else if (PUSH_flag) begin
            if (is_full) begin
              state      <= FAULT;
              fault      <= 1'b1;
              fault_code <= 2'b01;
            end else begin
              sp <= sp + 1'b1;
              pc <= pc_inc;
            end
          end else if (POP_flag) begin
            if (is_empty) begin
              state      <= FAULT;
              fault      <= 1'b1;
              fault_code <= 2'b10;
            end else begin
              sp       <= sp_m1;
              pc       <= pc_inc;
              wb_valid <= 1'b1;
              wb_reg   <= Mini_ALU_v1[7:0];
              wb_data  <= top_entry;
            end
          end else if (GSA_flag) begin
            pc       <= pc_inc;
            wb_valid <= 1'b1;
            wb_reg   <= Mini_ALU_v1[7:0];
            wb_data  <= 32'(sp);
          end else begin
            pc <= pc_inc;
          end
        end
      end else begin
        if (clear_fault) begin
          state      <= RUN;
          fault      <= 1'b0;
          fault_code <= 2'b00;
        end
      end
    end
  end

endmodule

// File: tb/tb_pc_stack_unit.sv
module tb_pc_stack_unit;

  localparam int DEPTH = 16;
  localparam int PW    = 16;
  localparam int unsigned MASK = 32'h0000_FFFF;

  localparam logic [6:0] F_CALL = 7'h40;
  localparam logic [6:0] F_RET  = 7'h20;
  localparam logic [6:0] F_JMP  = 7'h10;
  localparam logic [6:0] F_PUSH = 7'h08;
  localparam logic [6:0] F_POP  = 7'h04;
  localparam logic [6:0] F_GSA  = 7'h02;
  localparam logic [6:0] F_KERN = 7'h01;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          step = 1'b0;
  logic          JMP_flag = 1'b0, CALL_flag = 1'b0, RET_flag = 1'b0;
  logic          PUSH_flag = 1'b0, POP_flag = 1'b0, GSA_flag = 1'b0, Kernel_flag = 1'b0;
  logic [3:0]    Mini_ALU_op = 4'd0;
  logic [31:0]   Mini_ALU_v1 = 32'd0, Mini_ALU_v2 = 32'd0;
  logic          clear_fault = 1'b0;
  logic [PW-1:0] PC_pos;
  logic          wb_valid;
  logic [7:0]    wb_reg;
  logic [31:0]   wb_data;
  logic          stack_empty, stack_full, kernel_mode, fault;
  logic [1:0]    fault_code;

  always #5 clk = ~clk;

  pc_stack_unit #(.STACK_DEPTH(DEPTH), .PC_WIDTH(PW)) dut (
    .clk(clk), .rst_n(rst_n), .step(step),
    .JMP_flag(JMP_flag), .CALL_flag(CALL_flag), .RET_flag(RET_flag),
    .PUSH_flag(PUSH_flag), .POP_flag(POP_flag), .GSA_flag(GSA_flag),
    .Kernel_flag(Kernel_flag), .Mini_ALU_op(Mini_ALU_op),
    .Mini_ALU_v1(Mini_ALU_v1), .Mini_ALU_v2(Mini_ALU_v2),
    .clear_fault(clear_fault), .PC_pos(PC_pos), .wb_valid(wb_valid),
    .wb_reg(wb_reg), .wb_data(wb_data), .stack_empty(stack_empty),
    .stack_full(stack_full), .kernel_mode(kernel_mode), .fault(fault),
    .fault_code(fault_code)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: the stack is a plain queue, PC is integer arithmetic.
  int unsigned m_stack[$];
  int unsigned m_pc;
  bit          m_km, m_fault;
  bit [1:0]    m_code;
  bit          m_wbv;
  bit [7:0]    m_wbr;
  bit [31:0]   m_wbd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_stack.delete();
    m_pc = 0; m_km = 0; m_fault = 0; m_code = 2'b00;
    m_wbv = 0; m_wbr = 8'd0; m_wbd = 32'd0;
  endtask

  task automatic model_fault(input bit [1:0] code);
    m_fault = 1; m_code = code;
  endtask

  task automatic model_step();
    int unsigned tgt;
    tgt = (Mini_ALU_op[0] ? (Mini_ALU_v1 - Mini_ALU_v2) : (Mini_ALU_v1 + Mini_ALU_v2)) & MASK;
    m_wbv = 0;
    if (m_fault) begin
      if (clear_fault) begin m_fault = 0; m_code = 2'b00; end
    end else if (step) begin
      if (CALL_flag) begin
        if (m_stack.size() == DEPTH) model_fault(2'b01);
        else begin m_stack.push_back((m_pc + 1) & MASK); m_pc = tgt; end
      end else if (RET_flag) begin
        if (m_stack.size() == 0) model_fault(2'b10);
        else begin m_pc = m_stack.pop_back() & MASK; m_km = 0; end
      end else if (JMP_flag) begin
        m_pc = tgt;
        if (Kernel_flag) m_km = 1;
      end else if (PUSH_flag) begin
        if (m_stack.size() == DEPTH) model_fault(2'b01);
        else begin m_stack.push_back(Mini_ALU_v1); m_pc = (m_pc + 1) & MASK; end
      end else if (POP_flag) begin
        if (m_stack.size() == 0) model_fault(2'b10);
        else begin
          m_wbv = 1; m_wbr = Mini_ALU_v1[7:0]; m_wbd = m_stack.pop_back();
          m_pc = (m_pc + 1) & MASK;
        end
      end else if (GSA_flag) begin
        m_wbv = 1; m_wbr = Mini_ALU_v1[7:0]; m_wbd = m_stack.size();
        m_pc = (m_pc + 1) & MASK;
      end else begin
        m_pc = (m_pc + 1) & MASK;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc"},    32'(PC_pos),      m_pc);
    chk({tag, ".wbv"},   32'(wb_valid),    32'(m_wbv));
    chk({tag, ".wbr"},   32'(wb_reg),      32'(m_wbr));
    chk({tag, ".wbd"},   wb_data,          m_wbd);
    chk({tag, ".empty"}, 32'(stack_empty), 32'(m_stack.size() == 0));
    chk({tag, ".full"},  32'(stack_full),  32'(m_stack.size() == DEPTH));
    chk({tag, ".km"},    32'(kernel_mode), 32'(m_km));
    chk({tag, ".fault"}, 32'(fault),       32'(m_fault));
    chk({tag, ".code"},  32'(fault_code),  32'(m_code));
  endtask

  task automatic drive(input bit s, input logic [6:0] f, input logic [3:0] op,
                       input logic [31:0] v1, input logic [31:0] v2, input bit clr);
    step = s;
    CALL_flag = f[6]; RET_flag = f[5]; JMP_flag = f[4]; PUSH_flag = f[3];
    POP_flag = f[2]; GSA_flag = f[1]; Kernel_flag = f[0];
    Mini_ALU_op = op; Mini_ALU_v1 = v1; Mini_ALU_v2 = v2; clear_fault = clr;
  endtask

  // Called at a falling edge with inputs already driven.
  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic do_step(input string tag, input bit s, input logic [6:0] f, input logic [3:0] op,
                         input logic [31:0] v1, input logic [31:0] v2, input bit clr);
    drive(s, f, op, v1, v2, clr);
    tick(tag);
  endtask

  task automatic hard_reset(input string tag);
    drive(0, 7'h00, 4'd0, 32'd0, 32'd0, 0);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    check_all(tag);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [6:0] f;
    model_reset();
    drive(0, 7'h00, 4'd0, 32'd0, 32'd0, 0);
    repeat (2) @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;

    // Sequential increment, no write-back
    for (int i = 0; i < 3; i++) do_step("seq", 1, 7'h00, 4'd0, 32'd0, 32'd0, 0);
    chk("seq.pc3", 32'(PC_pos), 32'd3);

    // CALL / RET round trip from PC=5
    repeat (2) do_step("seq5", 1, 7'h00, 4'd0, 32'd0, 32'd0, 0);
    do_step("call", 1, F_CALL, 4'd0, 32'h40, 32'd0, 0);
    chk("call.pc", 32'(PC_pos), 32'h40);
    do_step("ret", 1, F_RET, 4'd0, 32'd0, 32'd0, 0);
    chk("ret.pc", 32'(PC_pos), 32'd6);

    // PUSH / POP write-back, then idle drops wb_valid
    do_step("push", 1, F_PUSH, 4'd0, 32'hDEADBEEF, 32'd0, 0);
    do_step("pop", 1, F_POP, 4'd0, 32'h03, 32'd0, 0);
    chk("pop.wbd", wb_data, 32'hDEADBEEF);
    do_step("idle", 0, 7'h00, 4'd0, 32'd0, 32'd0, 0);
    do_step("gsa", 1, F_GSA, 4'd0, 32'h1F7, 32'd0, 0);

    // Fill the stack, overflow on CALL, step ignored, clear
    for (int i = 0; i < DEPTH; i++) do_step("fill", 1, F_PUSH, 4'd0, $urandom, 32'd0, 0);
    chk("fill.full", 32'(stack_full), 32'd1);
    do_step("ovf", 1, F_CALL, 4'd0, 32'h200, 32'd0, 0);
    chk("ovf.code", 32'(fault_code), 32'd1);
    do_step("frozen", 1, 7'h00, 4'd0, 32'd0, 32'd0, 0);
    do_step("run.clr", 1, 7'h00, 4'd0, 32'd0, 32'd0, 1);
    do_step("clear", 0, 7'h00, 4'd0, 32'd0, 32'd0, 1);
    do_step("after", 1, F_PUSH, 4'd0, 32'h5, 32'd0, 0);

    // JMP subtraction wrap, kernel mode, RET clears it
    hard_reset("rst2");
    do_step("jmp10", 1, F_JMP, 4'd0, 32'h10, 32'd0, 0);
    do_step("jmpsub", 1, F_JMP, 4'hF, 32'h10, 32'h20, 0);
    chk("jmpsub.pc", 32'(PC_pos), 32'hFFF0);
    do_step("halt", 1, F_JMP, 4'd0, 32'hFFF0, 32'd0, 0);
    do_step("halt2", 1, F_JMP, 4'd0, 32'hFFF0, 32'd0, 0);
    do_step("jmpk", 1, F_JMP | F_KERN, 4'd0, 32'h100, 32'd0, 0);
    chk("jmpk.km", 32'(kernel_mode), 32'd1);
    do_step("callk", 1, F_CALL, 4'd0, 32'h300, 32'h4, 0);
    do_step("retk", 1, F_RET, 4'd0, 32'd0, 32'd0, 0);
    chk("retk.km", 32'(kernel_mode), 32'd0);
    do_step("wrapj", 1, F_JMP, 4'd0, 32'hFFFF, 32'd0, 0);
    do_step("wrap", 1, 7'h00, 4'd0, 32'd0, 32'd0, 0);

    // RET beats JMP on empty stack; then reset mid-cycle
    hard_reset("rst3");
    do_step("a", 1, 7'h00, 4'd0, 32'd0, 32'd0, 0);
    do_step("retjmp", 1, F_RET | F_JMP, 4'd0, 32'h77, 32'd0, 0);
    chk("retjmp.code", 32'(fault_code), 32'd2);
    do_step("clr2", 0, 7'h00, 4'd0, 32'd0, 32'd0, 1);
    do_step("push2", 1, F_PUSH, 4'd0, 32'hA5, 32'd0, 0);
    drive(1, F_GSA, 4'd0, 32'h9, 32'd0, 0);
    tick("gsa2");
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_all("midrst");
    @(posedge clk);
    #1 check_all("rsthold");
    @(negedge clk);
    rst_n = 1'b1;
    do_step("first", 1, 7'h00, 4'd0, 32'd0, 32'd0, 0);

    // Randomised run against the model
    for (int i = 0; i < 600; i++) begin
      f = 7'h00;
      if ($urandom_range(0, 7) == 0) f |= F_CALL;
      if ($urandom_range(0, 7) == 0) f |= F_RET;
      if ($urandom_range(0, 5) == 0) f |= F_JMP;
      if ($urandom_range(0, 2) == 0) f |= F_PUSH;
      if ($urandom_range(0, 3) == 0) f |= F_POP;
      if ($urandom_range(0, 5) == 0) f |= F_GSA;
      if ($urandom_range(0, 3) == 0) f |= F_KERN;
      drive($urandom_range(0, 3) != 0, f, 4'($urandom), $urandom, $urandom,
            $urandom_range(0, 3) == 0);
      if ($urandom_range(0, 9) == 0) begin
        Mini_ALU_v1 = 32'(PC_pos);
        Mini_ALU_v2 = 32'd0;
        Mini_ALU_op = 4'd0;
      end
      tick("rand");
      if (i % 200 == 199) hard_reset("rrst");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
